// File: rtl/load_store_unit.sv
// load_store_unit: single-request data-memory initiator with RMW sub-word stores and extended loads.
// Optional LSU_MISALIGN_CHECK_EN turns misaligned H/W accesses into errors instead of forcing alignment.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
    state_t state, state_nx;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, merged_q;
    logic        accept, illegal, misaligned, out_of_range, err;
    logic [4:0]  shamt;
    logic [31:0] shifted, load_ext, merged, byte_mask;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign accept = req_valid && req_ready;
    assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_write && req_funct3[2]);
`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign out_of_range = req_addr >= 32'(MEM_BYTES);
    assign err = illegal || misaligned || out_of_range;

    // Half lanes use only addr[1], so a misaligned half is implicitly forced to alignment.
    assign shamt     = {addr_q[1:0], 3'b000};
    assign shifted   = mem_read_data >> shamt;
    assign byte_v    = shifted[7:0];
    assign half_v    = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    assign load_ext  = f3_q[1] ? mem_read_data :
                       f3_q[0] ? {{16{~f3_q[2] & half_v[15]}}, half_v} :
                                 {{24{~f3_q[2] & byte_v[7]}}, byte_v};
    assign byte_mask = 32'h0000_00ff << shamt;
    assign merged    = f3_q[0] ? (addr_q[1] ? {wdata_q[15:0], mem_read_data[15:0]}
                                            : {mem_read_data[31:16], wdata_q[15:0]}) :
                                 ((mem_read_data & ~byte_mask) | ({24'b0, wdata_q[7:0]} << shamt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            f3_q       <= 3'b000;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            merged_q   <= 32'b0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (err) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= 32'b0;
                end
            end
            if (state == LOAD) begin
                resp_rdata <= load_ext;
                resp_err   <= 1'b0;
            end
            if (state == STORE || state == RMW_WR) begin
                resp_rdata <= 32'b0;
                resp_err   <= 1'b0;
            end
            if (state == RMW_RD) merged_q <= merged;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = err ? RESP : !req_write ? LOAD : req_funct3[1] ? STORE : RMW_RD;
            LOAD:    state_nx = RESP;
            STORE:   state_nx = RESP;
            RMW_RD:  state_nx = RMW_WR;
            RMW_WR:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = state == IDLE;
        resp_valid     = state == RESP;
        mem_read       = state == LOAD || state == RMW_RD;
        mem_write      = state == STORE || state == RMW_WR;
        mem_addr       = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'b0;
        mem_write_data = state == STORE ? wdata_q : state == RMW_WR ? merged_q : 32'b0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed vectors against a word-addressed memory model, plus reset corner case.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;
    logic        init = 1'b1;
    logic [31:0] mem [0:255];
    int passed = 0;
    int total = 0;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (init) begin
            mem[4]   <= 32'h8899_AABB;
            mem[8]   <= 32'h0000_0000;
            mem[255] <= 32'h7F00_0000;
        end else if (mem_write) mem[mem_addr[9:2]] <= mem_write_data;
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        rd;
        logic        wrx;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [0:21];

    function automatic vec_t mkv(logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] rdata, logic err, int lat, logic rd, logic wrx, logic [31:0] wd);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.lat = lat; v.rd = rd; v.wrx = wrx; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic run(input int idx, input vec_t v);
        int lat = 0;
        int nrd = 0;
        int nwr = 0;
        logic [31:0] maddr = 32'b0;
        logic [31:0] wd = 32'b0;
        chk($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_read) begin nrd++; maddr = mem_addr; end
            if (mem_write) begin nwr++; maddr = mem_addr; wd = mem_write_data; end
            if (resp_valid) begin lat = c; break; end
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d rdata", idx), resp_rdata, v.rdata);
        chk($sformatf("v%0d err", idx), 32'(resp_err), 32'(v.err));
        chk($sformatf("v%0d read_seen", idx), 32'(nrd != 0), 32'(v.rd));
        chk($sformatf("v%0d writes", idx), 32'(nwr), 32'(v.wrx));
        if (v.rd || v.wrx) chk($sformatf("v%0d mem_addr", idx), maddr, {v.addr[31:2], 2'b00});
        if (v.wrx) chk($sformatf("v%0d wdata", idx), wd, v.wd);
        @(negedge clk);
        chk($sformatf("v%0d pulse", idx), {30'b0, resp_valid, req_ready}, 32'd1);
        chk($sformatf("v%0d idle_addr", idx), mem_addr | mem_write_data, 32'b0);
        chk($sformatf("v%0d hold", idx), resp_rdata, v.rdata);
    endtask

    initial begin
        vecs[0]  = mkv(0, 3'b000, 32'h13, 0, 32'hFFFF_FF88, 0, 2, 1, 0, 0);
        vecs[1]  = mkv(0, 3'b100, 32'h13, 0, 32'h0000_0088, 0, 2, 1, 0, 0);
        vecs[2]  = mkv(0, 3'b001, 32'h10, 0, 32'hFFFF_AABB, 0, 2, 1, 0, 0);
        vecs[3]  = mkv(0, 3'b101, 32'h12, 0, 32'h0000_8899, 0, 2, 1, 0, 0);
        vecs[4]  = mkv(0, 3'b100, 32'h11, 0, 32'h0000_00AA, 0, 2, 1, 0, 0);
        vecs[5]  = mkv(1, 3'b000, 32'h11, 32'h1234_56CC, 0, 0, 3, 1, 1, 32'h8899_CCBB);
        vecs[6]  = mkv(0, 3'b010, 32'h10, 0, 32'h8899_CCBB, 0, 2, 1, 0, 0);
        vecs[7]  = mkv(1, 3'b001, 32'h12, 32'h0000_DEAD, 0, 0, 3, 1, 1, 32'hDEAD_CCBB);
        vecs[8]  = mkv(0, 3'b101, 32'h12, 0, 32'h0000_DEAD, 0, 2, 1, 0, 0);
        vecs[9]  = mkv(0, 3'b001, 32'h12, 0, 32'hFFFF_DEAD, 0, 2, 1, 0, 0);
        vecs[10] = mkv(0, 3'b000, 32'h13, 0, 32'hFFFF_FFDE, 0, 2, 1, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        vecs[11] = mkv(0, 3'b010, 32'h12, 0, 0, 1, 1, 0, 0, 0);
`else
        vecs[11] = mkv(0, 3'b010, 32'h12, 0, 32'hDEAD_CCBB, 0, 2, 1, 0, 0);
`endif
        vecs[12] = mkv(1, 3'b010, 32'h400, 32'hFFFF_FFFF, 0, 1, 1, 0, 0, 0);
        vecs[13] = mkv(0, 3'b011, 32'h20, 0, 0, 1, 1, 0, 0, 0);
        vecs[14] = mkv(1, 3'b100, 32'h20, 32'h1111_1111, 0, 1, 1, 0, 0, 0);
        vecs[15] = mkv(0, 3'b000, 32'h400, 0, 0, 1, 1, 0, 0, 0);
        vecs[16] = mkv(0, 3'b100, 32'h3FF, 0, 32'h0000_007F, 0, 2, 1, 0, 0);
        vecs[17] = mkv(1, 3'b010, 32'h20, 32'hCAFE_F00D, 0, 0, 2, 0, 1, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_CHECK_EN
        vecs[18] = mkv(1, 3'b001, 32'h21, 32'h0000_1234, 0, 1, 1, 0, 0, 0);
        vecs[19] = mkv(0, 3'b010, 32'h20, 0, 32'hCAFE_F00D, 0, 2, 1, 0, 0);
`else
        vecs[18] = mkv(1, 3'b001, 32'h21, 32'h0000_1234, 0, 0, 3, 1, 1, 32'hCAFE_1234);
        vecs[19] = mkv(0, 3'b010, 32'h20, 0, 32'hCAFE_1234, 0, 2, 1, 0, 0);
`endif
        vecs[20] = mkv(1, 3'b110, 32'h20, 32'h2222_2222, 0, 1, 1, 0, 0, 0);
        vecs[21] = mkv(0, 3'b111, 32'h20, 0, 0, 1, 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("reset outputs", {resp_rdata | mem_addr | mem_write_data}, 32'b0);
        chk("reset flags", {27'b0, req_ready, resp_valid, resp_err, mem_read, mem_write}, 32'h10);
        init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 22; i++) run(i, vecs[i]);

        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h0000_0011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_rd reached", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {resp_rdata | mem_addr | mem_write_data}, 32'b0);
        chk("async reset flags", {27'b0, req_ready, resp_valid, resp_err, mem_read, mem_write}, 32'h10);
        repeat (2) @(negedge clk);
        chk("reset hold", {30'b0, mem_write, mem_read}, 32'b0);
        rst_n = 1'b1;
        @(negedge clk);
        run(100, mkv(0, 3'b010, 32'h10, 0, 32'hDEAD_CCBB, 0, 2, 1, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
